// File: rtl/systolic_act_feeder.sv
// -----------------------------------------------------------------------------
// systolic_act_feeder
//
// Purpose:
//   Accepts activation vectors (one lane per systolic array row) and presents
//   them skewed in time. Lane r of a vector reaches the array r advances after
//   lane 0. The skew pipeline only moves on an "advance", so an input stall
//   freezes the array. After the last vector of a tile, zeros are shifted in
//   for ROWS-1 further advances so every lane fully drains. Then done pulses.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           tile request, only looked at while idle
//   tile_len        number of vectors in the tile, latched with start
//   in_valid/ready  input handshake; in_data lane r = [r*DATA_WIDTH +: DATA_WIDTH]
//   quantize_mode   (only with ACT_FEEDER_INT4_SAT_EN) saturate lanes to int4
//   act_row         skewed lanes, lane r drives array row r
//   pe_enable       array advance strobe, aligned with act_row
//   busy            high whenever not idle
//   done            one-cycle pulse once the tile has drained
//
// Build option:
//   ACT_FEEDER_INT4_SAT_EN  adds quantize_mode. When quantize_mode is high,
//                           each lane is saturated to [-8,7] and sign-extended
//                           when it is accepted.
// -----------------------------------------------------------------------------
module systolic_act_feeder #(
  parameter int ROWS       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [LEN_WIDTH-1:0]         tile_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]   in_data,
`ifdef ACT_FEEDER_INT4_SAT_EN
  input  logic                         quantize_mode,
`endif
  output logic [ROWS*DATA_WIDTH-1:0]   act_row,
  output logic                         pe_enable,
  output logic                         busy,
  output logic                         done
);

  localparam int DRAIN_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_PRESET = DRAIN_W'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] acc_cnt_q, acc_cnt_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic                 pe_enable_q, pe_enable_d;
  logic                 accept;
  logic                 advance;

`ifdef ACT_FEEDER_INT4_SAT_EN
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {{(DATA_WIDTH-3){1'b0}}, 3'b111};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {{(DATA_WIDTH-3){1'b1}}, 3'b000};

  // Clamp a signed lane to the int4 range, keeping it sign-extended.
  function automatic logic [DATA_WIDTH-1:0] sat_int4(input logic signed [DATA_WIDTH-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX;
    end else if (v < SAT_MIN) begin
      return SAT_MIN;
    end
    return v;
  endfunction
`endif

  assign in_ready  = (state_q == STREAM);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid && in_ready;
  assign pe_enable = pe_enable_q;

  // Control: tile sequencing, counters and the advance strobe.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_cnt_d   = acc_cnt_q;
    drain_cnt_d = drain_cnt_q;
    advance     = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d     = tile_len;
          acc_cnt_d = '0;
          if (tile_len != '0) begin
            state_d = STREAM;
          end else begin
            // An empty tile still runs one DRAIN cycle so it gets a done pulse.
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      STREAM: begin
        if (accept) begin
          advance   = 1'b1;
          acc_cnt_d = acc_cnt_q + LEN_WIDTH'(1);
          if (acc_cnt_d == len_q) begin
            state_d     = DRAIN;
            drain_cnt_d = DRAIN_PRESET;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt_q != '0) begin
          advance     = 1'b1;
          drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    pe_enable_d = advance;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      acc_cnt_q   <= '0;
      drain_cnt_q <= '0;
      pe_enable_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_cnt_q   <= acc_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      pe_enable_q <= pe_enable_d;
    end
  end

  // Skew pipeline: lane r is a shift register of r+1 stages.
  // Its last stage drives act_row, so the output only changes when pe_enable is high.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DATA_WIDTH-1:0] raw;
    logic [DATA_WIDTH-1:0] lane_in;
    logic [DATA_WIDTH-1:0] pipe_q [0:r];
    logic [DATA_WIDTH-1:0] pipe_d [0:r];

    assign raw = in_data[r*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
      // Outside STREAM the only advances are drain advances, which feed zeros.
      lane_in = '0;
      if (state_q == STREAM) begin
`ifdef ACT_FEEDER_INT4_SAT_EN
        lane_in = quantize_mode ? sat_int4(raw) : raw;
`else
        lane_in = raw;
`endif
      end
      for (int k = 0; k <= r; k++) begin
        pipe_d[k] = pipe_q[k];
      end
      if (advance) begin
        pipe_d[0] = lane_in;
        for (int k = 1; k <= r; k++) begin
          pipe_d[k] = pipe_q[k-1];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= r; k++) begin
          pipe_q[k] <= '0;
        end
      end else begin
        for (int k = 0; k <= r; k++) begin
          pipe_q[k] <= pipe_d[k];
        end
      end
    end

    assign act_row[r*DATA_WIDTH +: DATA_WIDTH] = pipe_q[r];
  end

endmodule
